// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// riscv_defs
// Shared types for the unified-memory port arbiter.
//   arb_owner_e : which pipeline port issued a memory transaction
//   arb_state_e : arbiter FSM states
//   hold_state  : maps an owner to the state that holds its request
// ---------------------------------------------------------------------------
package riscv_defs;

   typedef enum logic {
      OWNER_IF,
      OWNER_D
   } arb_owner_e;

   typedef enum logic [1:0] {
      IDLE,
      HOLD_IF,
      HOLD_D
   } arb_state_e;

   function automatic arb_state_e hold_state(input arb_owner_e owner);
      return (owner == OWNER_IF) ? HOLD_IF : HOLD_D;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory port and the sticky error flag
// of the memory port arbiter.
//   slave  : arbiter view (consumes i_* and drives o_*)
//   master : environment view (drives i_* and observes o_*)
// Parameters: NB_ADDR address width, NB_WORD data width.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int NB_ADDR = 32,
   parameter int NB_WORD = 32
);

   logic                 i_if_req;
   logic [NB_ADDR-1:0]   i_if_addr;
   logic                 o_if_gnt;
   logic                 o_if_rvalid;
   logic [NB_WORD-1:0]   o_if_rdata;

   logic                 i_d_req;
   logic                 i_d_we;
   logic [NB_WORD/8-1:0] i_d_be;
   logic [NB_ADDR-1:0]   i_d_addr;
   logic [NB_WORD-1:0]   i_d_wdata;
   logic                 o_d_gnt;
   logic                 o_d_rvalid;
   logic [NB_WORD-1:0]   o_d_rdata;

   logic                 o_mem_req;
   logic                 o_mem_we;
   logic [NB_WORD/8-1:0] o_mem_be;
   logic [NB_ADDR-1:0]   o_mem_addr;
   logic [NB_WORD-1:0]   o_mem_wdata;
   logic                 i_mem_gnt;
   logic                 i_mem_rvalid;
   logic [NB_WORD-1:0]   i_mem_rdata;

   logic                 o_err;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
      output o_d_gnt, o_d_rvalid, o_d_rdata,
      output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      output o_err
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
      input  o_d_gnt, o_d_rvalid, o_d_rdata,
      input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      input  o_err
   );

endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// ---------------------------------------------------------------------------
// arb_tag_fifo
// In-order FIFO of owner tags, one entry per granted memory transaction.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_push, i_tag    : record the owner of a newly granted transaction
//   i_pop            : retire the head when its response arrives
//   o_head           : owner of the oldest outstanding transaction
//   o_full, o_empty  : occupancy flags
// A push and a pop in the same cycle are accepted even when full.
// ---------------------------------------------------------------------------
module arb_tag_fifo
   import riscv_defs::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_push,
   input  logic       i_pop,
   input  arb_owner_e i_tag,
   output arb_owner_e o_head,
   output logic       o_full,
   output logic       o_empty
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   arb_owner_e       tags_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign o_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign o_empty = (count_q == '0);
   assign o_head  = tags_q[rd_ptr_q];

   // A pop frees the slot a same-cycle push needs, so full only blocks a
   // push when nothing retires in that cycle.
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   // Pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage and pointers; reset abandons every outstanding tag.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tags_q[i] <= OWNER_IF;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            tags_q[wr_ptr_q] <= i_tag;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and the data
// (memory-stage) port. Data wins by default; a presented request is held
// until the memory grants it; owners of granted transactions are queued so
// in-order responses are routed back to the port that issued them.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus (slave)      : fetch port, data port, memory port, sticky o_err
// Parameters: NB_ADDR, NB_WORD, MAX_OUTSTANDING (power of 2, >= 1).
// Optional macro ARB_STARVE_GUARD_EN adds STARVE_LIMIT and a counter that
// forces fetch to win after STARVE_LIMIT consecutive losses to data.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import riscv_defs::*;
#(
   parameter int NB_ADDR         = 32,
   parameter int NB_WORD         = 32,
   parameter int MAX_OUTSTANDING = 2
`ifdef ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT    = 4
`endif
) (
   input logic               i_clock,
   input logic               i_reset,
   mem_port_arbiter_if.slave bus
);

   arb_state_e           state_q, state_d;
   arb_owner_e           sel_owner;
   arb_owner_e           fifo_head;
   logic                 sel_valid;
   logic                 mem_req;
   logic                 grant;
   logic                 fifo_full, fifo_empty, fifo_pop, can_push;
   logic                 starve_force;
   logic                 err_q, err_d;
   logic                 rsp_if, rsp_d;
   logic                 sel_we;
   logic [NB_WORD/8-1:0] sel_be;
   logic [NB_ADDR-1:0]   sel_addr;
   logic [NB_WORD-1:0]   sel_wdata;

   // A response retires the head tag; with nothing outstanding it is dropped.
   assign fifo_pop = bus.i_mem_rvalid && !fifo_empty && !i_reset;
   assign can_push = !fifo_full || fifo_pop;

   // Arbitration and hold FSM. In IDLE the winner is chosen and presented in
   // the same cycle; a presented but ungranted request is locked in HOLD_x
   // so the other port cannot preempt it. A full tag FIFO suppresses the
   // request entirely, and IDLE simply re-arbitrates once room appears.
   always_comb begin
      state_d   = state_q;
      sel_owner = OWNER_D;
      sel_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_if_req && (!bus.i_d_req || starve_force)) begin
               sel_owner = OWNER_IF;
               sel_valid = 1'b1;
            end else if (bus.i_d_req) begin
               sel_owner = OWNER_D;
               sel_valid = 1'b1;
            end
         end
         HOLD_IF: begin
            sel_owner = OWNER_IF;
            sel_valid = 1'b1;
         end
         HOLD_D: begin
            sel_owner = OWNER_D;
            sel_valid = 1'b1;
         end
         default: begin
            sel_valid = 1'b0;
         end
      endcase
      mem_req = sel_valid && can_push && !i_reset;
      grant   = mem_req && bus.i_mem_gnt;
      if (state_q == IDLE) begin
         if (mem_req && !grant) begin
            state_d = hold_state(sel_owner);
         end
      end else if (grant) begin
         state_d = IDLE;
      end
   end

   // Memory-side request fields; fetch is always a full-word read.
   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (sel_valid && !i_reset) begin
         if (sel_owner == OWNER_IF) begin
            sel_be   = '1;
            sel_addr = bus.i_if_addr;
         end else begin
            sel_we    = bus.i_d_we;
            sel_be    = bus.i_d_be;
            sel_addr  = bus.i_d_addr;
            sel_wdata = bus.i_d_wdata;
         end
      end
   end

   assign bus.o_mem_req   = mem_req;
   assign bus.o_mem_we    = sel_we;
   assign bus.o_mem_be    = sel_be;
   assign bus.o_mem_addr  = sel_addr;
   assign bus.o_mem_wdata = sel_wdata;
   assign bus.o_if_gnt    = grant && (sel_owner == OWNER_IF);
   assign bus.o_d_gnt     = grant && (sel_owner == OWNER_D);

   assign rsp_if          = fifo_pop && (fifo_head == OWNER_IF);
   assign rsp_d           = fifo_pop && (fifo_head == OWNER_D);
   assign bus.o_if_rvalid = rsp_if;
   assign bus.o_if_rdata  = rsp_if ? bus.i_mem_rdata : '0;
   assign bus.o_d_rvalid  = rsp_d;
   assign bus.o_d_rdata   = rsp_d ? bus.i_mem_rdata : '0;

   assign err_d     = err_q || (bus.i_mem_rvalid && fifo_empty);
   assign bus.o_err = err_q;

   // State register and sticky protocol error.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_q, starve_d;

   // Counts IDLE arbitrations that fetch lost to data; a fetch grant or an
   // idle fetch port clears it, and reaching the limit hands fetch the next
   // IDLE arbitration.
   always_comb begin
      starve_d = starve_q;
      if (!bus.i_if_req || (grant && (sel_owner == OWNER_IF))) begin
         starve_d = '0;
      end else if ((state_q == IDLE) && mem_req && (sel_owner == OWNER_D) &&
                   (starve_q != STARVE_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign starve_force = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
   assign starve_force = 1'b0;
`endif

   arb_tag_fifo #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_tag_fifo (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_push (grant),
      .i_pop  (fifo_pop),
      .i_tag  (sel_owner),
      .o_head (fifo_head),
      .o_full (fifo_full),
      .o_empty(fifo_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized phase. A reference model keeps
// a queue of issuing ports, the port whose request is locked awaiting a
// grant, the sticky error and the fetch-loss count, and predicts every
// output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int NA     = 32;
   localparam int NW     = 32;
   localparam int MAXO   = 2;
   localparam int STARVE = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NB_ADDR(NA), .NB_WORD(NW)) bus ();

   mem_port_arbiter #(
      .NB_ADDR        (NA),
      .NB_WORD        (NW),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: ports of outstanding transactions (0 fetch, 1 data),
   // locked port (-1 none), sticky error, consecutive fetch losses.
   int ownQ[$];
   int lockOwner = -1;
   bit errM      = 1'b0;
   int starveM   = 0;

   // Predictions made before the clock edge, committed after it.
   bit pPop, pGnt, pReq, pErrEv, pIfReq;
   int pWin = -1;
   int ifGrantCount = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives every DUT input, then lets combinational outputs settle.
   task automatic applyStimulus(input bit ifReq, input logic [31:0] ifAddr,
                                input bit dReq, input bit dWe, input logic [3:0] dBe,
                                input logic [31:0] dAddr, input logic [31:0] dWdata,
                                input bit memGnt, input bit memRvalid,
                                input logic [31:0] memRdata);
      bus.i_if_req     = ifReq;
      bus.i_if_addr    = ifAddr;
      bus.i_d_req      = dReq;
      bus.i_d_we       = dWe;
      bus.i_d_be       = dBe;
      bus.i_d_addr     = dAddr;
      bus.i_d_wdata    = dWdata;
      bus.i_mem_gnt    = memGnt;
      bus.i_mem_rvalid = memRvalid;
      bus.i_mem_rdata  = memRdata;
      #3;
   endtask

   // Predicts all outputs from the model and current inputs and compares.
   task automatic checkOutput();
      int qs, win;
      bit pop, room, forceIf, eReq, eGnt, eIfRv, eDRv, eWe, eErr;
      logic [3:0]  eBe;
      logic [31:0] eAddr, eWd, eIfRd, eDRd;
      win = -1; pop = 0; eReq = 0; eGnt = 0; eIfRv = 0; eDRv = 0; eWe = 0;
      eBe = '0; eAddr = '0; eWd = '0; eIfRd = '0; eDRd = '0; eErr = 0;
      pErrEv = 0;
      if (!rst) begin
         qs = ownQ.size();
         pop = bus.i_mem_rvalid && (qs > 0);
         room = (qs < MAXO) || pop;
`ifdef ARB_STARVE_GUARD_EN
         forceIf = (starveM == STARVE);
`else
         forceIf = 1'b0;
`endif
         if (lockOwner >= 0) win = lockOwner;
         else if (bus.i_if_req && (!bus.i_d_req || forceIf)) win = 0;
         else if (bus.i_d_req) win = 1;
         eReq = (win >= 0) && room;
         eGnt = eReq && bus.i_mem_gnt;
         if (win == 0) begin
            eBe = 4'hF; eAddr = bus.i_if_addr;
         end else if (win == 1) begin
            eWe = bus.i_d_we; eBe = bus.i_d_be; eAddr = bus.i_d_addr; eWd = bus.i_d_wdata;
         end
         if (pop) begin
            eIfRv = (ownQ[0] == 0);
            eDRv  = (ownQ[0] == 1);
         end
         if (eIfRv) eIfRd = bus.i_mem_rdata;
         if (eDRv)  eDRd  = bus.i_mem_rdata;
         eErr   = errM;
         pErrEv = bus.i_mem_rvalid && (qs == 0);
      end
      pPop = pop; pGnt = eGnt; pReq = eReq; pWin = win; pIfReq = bus.i_if_req;
      if (bus.o_if_gnt === 1'b1) ifGrantCount++;
      chk("if_gnt",    32'(bus.o_if_gnt),    32'(eGnt && win == 0));
      chk("d_gnt",     32'(bus.o_d_gnt),     32'(eGnt && win == 1));
      chk("mem_req",   32'(bus.o_mem_req),   32'(eReq));
      chk("mem_we",    32'(bus.o_mem_we),    32'(eWe));
      chk("mem_be",    32'(bus.o_mem_be),    32'(eBe));
      chk("mem_addr",  bus.o_mem_addr,       eAddr);
      chk("mem_wdata", bus.o_mem_wdata,      eWd);
      chk("if_rvalid", 32'(bus.o_if_rvalid), 32'(eIfRv));
      chk("if_rdata",  bus.o_if_rdata,       eIfRd);
      chk("d_rvalid",  32'(bus.o_d_rvalid),  32'(eDRv));
      chk("d_rdata",   bus.o_d_rdata,        eDRd);
      chk("err",       32'(bus.o_err),       32'(eErr));
   endtask

   // Advances one clock and commits the predicted model update.
   task automatic tick();
      int prevLock;
      @(posedge clk);
      if (rst) begin
         ownQ.delete();
         lockOwner = -1;
         errM      = 1'b0;
         starveM   = 0;
      end else begin
         prevLock = lockOwner;
         if (pPop) void'(ownQ.pop_front());
         if (pGnt) ownQ.push_back(pWin);
         if (prevLock < 0) lockOwner = (pReq && !pGnt) ? pWin : -1;
         else if (pGnt) lockOwner = -1;
         if (pErrEv) errM = 1'b1;
         if ((pGnt && pWin == 0) || !pIfReq) starveM = 0;
         else if (prevLock < 0 && pReq && pWin == 1) starveM++;
      end
      #1;
   endtask

   initial begin
      bit          rIf, rD, rWe, rGnt, rRv;
      logic [3:0]  rBe;
      logic [31:0] rIfA, rDA, rWd;
      int          expIfGrants;

      // Reset with every input active: all outputs must stay 0.
      rst = 1'b1;
      applyStimulus(1, 32'h100, 1, 1, 4'hF, 32'h2000, 32'h1, 1, 1, 32'h5);
      checkOutput();
      chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
      chk("rst_d_gnt",   32'(bus.o_d_gnt),   32'd0);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(); tick();

      // Both ports request with an eager memory: data first, then fetch.
      applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h2000, 0, 1, 0, 0);
      checkOutput();
      chk("A_d_gnt", 32'(bus.o_d_gnt), 32'd1);
      chk("A_if_gnt0", 32'(bus.o_if_gnt), 32'd0);
      chk("A_addr_d", bus.o_mem_addr, 32'h2000);
      tick();
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput();
      chk("A_if_gnt1", 32'(bus.o_if_gnt), 32'd1);
      chk("A_addr_if", bus.o_mem_addr, 32'h100);
      chk("A_be_if", 32'(bus.o_mem_be), 32'hF);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA);
      checkOutput();
      chk("A_rsp1_d", bus.o_d_rdata, 32'hAAAA);
      chk("A_rsp1_if", 32'(bus.o_if_rvalid), 32'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB);
      checkOutput();
      chk("A_rsp2_if", bus.o_if_rdata, 32'hBBBB);
      chk("A_rsp2_d", 32'(bus.o_d_rvalid), 32'd0);
      tick();

      // Fetch held while memory stalls; data must wait behind it.
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(); tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0);
         checkOutput();
         chk("B_hold_addr", bus.o_mem_addr, 32'h100);
         tick();
      end
      applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0);
      checkOutput();
      chk("B_if_gnt", 32'(bus.o_if_gnt), 32'd1);
      tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0);
      checkOutput();
      chk("B_d_gnt", 32'(bus.o_d_gnt), 32'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11 + i);
         checkOutput(); tick();
      end

      // Tag FIFO full: request suppressed until a response frees a slot.
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h4000, 0, 1, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h4004, 0, 1, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h4008, 0, 1, 0, 0);
      checkOutput();
      chk("C_full_req", 32'(bus.o_mem_req), 32'd0);
      tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h4008, 0, 1, 1, 32'h21);
      checkOutput();
      chk("C_pop_push_gnt", 32'(bus.o_d_gnt), 32'd1);
      tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h400C, 0, 1, 0, 0);
      checkOutput();
      chk("C_still_full", 32'(bus.o_mem_req), 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22 + i);
         checkOutput(); tick();
      end

      // Data write and its acknowledgement.
      applyStimulus(0, 0, 1, 1, 4'b0011, 32'h5000, 32'hDEADBEEF, 1, 0, 0);
      checkOutput();
      chk("D_we", 32'(bus.o_mem_we), 32'd1);
      chk("D_be", 32'(bus.o_mem_be), 32'h3);
      chk("D_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      checkOutput();
      chk("D_ack_d", 32'(bus.o_d_rvalid), 32'd1);
      chk("D_ack_if", 32'(bus.o_if_rvalid), 32'd0);
      tick();

      // Response with nothing outstanding: dropped, sticky error.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
      checkOutput();
      chk("E_drop_d", 32'(bus.o_d_rvalid), 32'd0);
      chk("E_drop_if", 32'(bus.o_if_rvalid), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         checkOutput();
         chk("E_err_sticky", 32'(bus.o_err), 32'd1);
         tick();
      end

      // Asynchronous reset while holding a data request.
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h6000, 0, 0, 0, 0); checkOutput(); tick();
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h6000, 0, 0, 0, 0); checkOutput();
      chk("F_hold_d", bus.o_mem_addr, 32'h6000);
      rst = 1'b1;
      #1;
      checkOutput();
      chk("F_async_req", 32'(bus.o_mem_req), 32'd0);
      chk("F_async_err", 32'(bus.o_err), 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(1, 32'h7000, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput();
      chk("F_idle_if_gnt", 32'(bus.o_if_gnt), 32'd1);
      tick();

      // Both ports request continuously with an eager memory.
      ifGrantCount = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 32'h8000 + 32'(i * 4), 1, 0, 4'hF, 32'h9000 + 32'(i * 4), 0,
                       1, ownQ.size() > 0, $urandom);
         checkOutput(); tick();
      end
`ifdef ARB_STARVE_GUARD_EN
      expIfGrants = 4;
`else
      expIfGrants = 0;
`endif
      chk("G_if_grants", 32'(ifGrantCount), 32'(expIfGrants));

      // Randomized traffic; a request not yet granted is held unchanged.
      for (int c = 0; c < 400; c++) begin
         if (bus.i_if_req && !(pGnt && pWin == 0)) begin
            rIf = 1'b1; rIfA = bus.i_if_addr;
         end else begin
            rIf = 1'($urandom_range(0, 1)); rIfA = $urandom & 32'hFFFF_FFFC;
         end
         if (bus.i_d_req && !(pGnt && pWin == 1)) begin
            rD = 1'b1; rWe = bus.i_d_we; rBe = bus.i_d_be; rDA = bus.i_d_addr; rWd = bus.i_d_wdata;
         end else begin
            rD = 1'($urandom_range(0, 1)); rWe = 1'($urandom_range(0, 1));
            rBe = 4'($urandom); rDA = $urandom; rWd = $urandom;
         end
         rGnt = ($urandom_range(0, 3) != 0);
         rRv  = (ownQ.size() > 0) && 1'($urandom_range(0, 1));
         applyStimulus(rIf, rIfA, rD, rWe, rBe, rDA, rWd, rGnt, rRv, $urandom);
         checkOutput(); tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
